knight_attack_sequencer: RTL
============================

# knight_attack_sequencer

Sequences the knight's attack animation and generates the sprite ROM address for the frame being played. On an accepted attack request, it steps through the attack frames at a rate set by vertical-blank ticks, then runs a cooldown period. Each cycle it maps the current scan position (DrawX, DrawY) to a ROM address inside the 50x64 sprite box at (sprite_x, sprite_y). It sits between the game-logic FSM and the per-frame sprite ROM/palette muxing.

## Interface
- SPRITE_W, 50: sprite width in pixels
- SPRITE_H, 64: sprite height in pixels
- NUM_FRAMES, 5: number of attack frames; frame_sel covers 0..NUM_FRAMES-1
- HOLD_TICKS, 4: frame_tick pulses each frame is held; must be ≥1
- COOLDOWN_TICKS, 8: frame_tick pulses in cooldown; 0 is legal
- HIT_FIRST, 2 / HIT_LAST, 3: inclusive frame range in which the hitbox is live
- vga_clk  in  1  pixel clock; all logic runs on its rising edge
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per video frame (vsync edge)
- attack_req  in  1  level/pulse request to start an attack
- facing_left  in  1  sprite is mirrored horizontally
- sprite_x, sprite_y  in  10 each  top-left corner of the sprite on screen
- DrawX, DrawY  in  10 each  current scan position
- rom_address  out  12  sprite ROM address
- in_sprite  out  1  the current pixel lies inside the sprite box
- frame_sel  out  3  current attack frame index
- busy  out  1  high in PLAY or COOLDOWN
- hit_active  out  1  attack hitbox is live
- attack_done  out  1  one-cycle pulse when the last frame completes

## Operation
- **FSM states:** IDLE, PLAY, COOLDOWN.
- **IDLE:**
  - attack_req=1 → PLAY with frame_sel=0 and hold_cnt=0.
  - A frame_tick in the same cycle as attack_req is not counted.
- **PLAY, on each frame_tick:**
  - If hold_cnt < HOLD_TICKS-1, hold_cnt increments.
  - Otherwise hold_cnt returns to 0.
    - If frame_sel < NUM_FRAMES-1, frame_sel increments.
    - Else attack_done pulses and the FSM enters COOLDOWN, or IDLE directly if COOLDOWN_TICKS=0. frame_sel returns to 0.
- **COOLDOWN:**
  - A counter counts COOLDOWN_TICKS frame_ticks.
  - The FSM enters IDLE on the tick that reaches COOLDOWN_TICKS.
- **Request handling:** attack_req is ignored in PLAY and COOLDOWN. There is no queueing. A request held high across the return to IDLE restarts the attack on the first IDLE cycle.
- **hit_active:** = (state==PLAY) && HIT_FIRST ≤ frame_sel ≤ HIT_LAST.
- **Address path:**
  - Compare in 11-bit unsigned so there is no wrap: in_sprite = DrawX ≥ sprite_x && DrawX < sprite_x+SPRITE_W && DrawY ≥ sprite_y && DrawY < sprite_y+SPRITE_H.
  - lx = DrawX−sprite_x and ly = DrawY−sprite_y, both truncated to 6 bits.
  - rom_address = ly*SPRITE_W + lx_eff. It is forced to 0 when in_sprite=0.
  - The maximum value is 3199, which fits in 12 bits.
- **Reset mid-operation:** returns the FSM to IDLE and clears all counters immediately. No attack_done pulse is generated.

## Timing
- **Reset values:** rom_address=0, in_sprite=0, frame_sel=0, busy=0, hit_active=0, attack_done=0; state=IDLE.
- **Address path latency:** rom_address and in_sprite are registered, 1 cycle after DrawX/DrawY. The downstream ROM samples on the negedge of the same cycle.
- **FSM outputs:** frame_sel, busy, hit_active and attack_done are registered and change the cycle after the causing event.
- **Attack length:** with default parameters, PLAY lasts exactly NUM_FRAMES*HOLD_TICKS = 20 frame_ticks after acceptance.

## Configuration
- **KNIGHT_ATK_MIRROR_EN defined:** lx_eff = facing_left ? SPRITE_W-1-lx : lx. facing_left is sampled every cycle.
- **KNIGHT_ATK_MIRROR_EN undefined:** lx_eff = lx. facing_left is unused and does not affect any output.

## Test plan
- **Reset:** assert Reset for 2 cycles mid-PLAY at frame 3 → all outputs 0 next cycle and state IDLE; no attack_done pulse.
- **Full sequence:** attack_req pulse in IDLE, then 20 frame_ticks.
  - frame_sel steps 0,1,2,3,4, changing every 4 ticks.
  - hit_active is high only for frames 2–3.
  - attack_done pulses once on tick 20, and busy stays high 8 more ticks.
- **Ignored request and simultaneous tick:** attack_req during PLAY → no restart. attack_req together with frame_tick in IDLE → the first frame advance occurs on the 4th subsequent tick.
- **Address mapping:** sprite_x=100, sprite_y=200.
  - DrawX=149, DrawY=263 → in_sprite=1, rom_address=3199 one cycle later.
  - DrawX=150 → in_sprite=0, rom_address=0.
  - DrawX=99 → in_sprite=0.
- **Mirroring (KNIGHT_ATK_MIRROR_EN defined):** facing_left=1, DrawX=100, DrawY=200 with sprite at (100,200) → rom_address=49. With the macro undefined → 0.
- **No cooldown:** COOLDOWN_TICKS=0 → the FSM returns to IDLE in the cycle after attack_done, and a held attack_req restarts at frame 0.

Source files
------------

// File: rtl/knight_attack_sequencer_if.sv
// Bundle between the game-logic FSM and the knight attack sequencer.
// The master side drives requests and scan position; the slave side returns sprite status.
interface knight_attack_sequencer_if;
    logic        frame_tick;
    logic        attack_req;
    logic        facing_left;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [11:0] rom_address;
    logic        in_sprite;
    logic [2:0]  frame_sel;
    logic        busy;
    logic        hit_active;
    logic        attack_done;
    logic [1:0]  fsm_state;

    // No ready path: attack_req is a level sampled only while idle and frame_tick is a
    // one-cycle strobe. Every output is registered and valid every cycle.
    modport master (
        output frame_tick, attack_req, facing_left, sprite_x, sprite_y, DrawX, DrawY,
        input  rom_address, in_sprite, frame_sel, busy, hit_active, attack_done, fsm_state
    );

    modport slave (
        input  frame_tick, attack_req, facing_left, sprite_x, sprite_y, DrawX, DrawY,
        output rom_address, in_sprite, frame_sel, busy, hit_active, attack_done, fsm_state
    );
endinterface

// File: rtl/knight_attack_sequencer.sv
// Knight attack animation sequencer and sprite ROM address generator.
// Define KNIGHT_ATK_MIRROR_EN to mirror the sprite horizontally when facing_left is high.
module knight_attack_sequencer #(
    parameter int SPRITE_W       = 50,
    parameter int SPRITE_H       = 64,
    parameter int NUM_FRAMES     = 5,
    parameter int HOLD_TICKS     = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int HIT_FIRST      = 2,
    parameter int HIT_LAST       = 3
) (
    input  logic vga_clk,
    input  logic Reset,
    knight_attack_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [7:0]  COOL_LAST  = (COOLDOWN_TICKS == 0) ? 8'd0 : 8'(COOLDOWN_TICKS - 1);
    localparam logic [2:0]  FRAME_LAST = 3'(NUM_FRAMES - 1);
    localparam logic [2:0]  HIT_LO     = 3'(HIT_FIRST);
    localparam logic [2:0]  HIT_HI     = 3'(HIT_LAST);
    localparam logic [10:0] BOX_W      = 11'(SPRITE_W);
    localparam logic [10:0] BOX_H      = 11'(SPRITE_H);

    state_t      state_q, state_d;
    logic [2:0]  frame_q, frame_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  cool_q, cool_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        hit_q, hit_d;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_q <= 3'd0;
            hold_q  <= 8'd0;
            cool_q  <= 8'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        cool_d  = cool_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A tick arriving with the request is deliberately not counted.
                if (bus.attack_req) begin
                    state_d = PLAY;
                    frame_d = 3'd0;
                    hold_d  = 8'd0;
                end
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    if (hold_q < HOLD_LAST) begin
                        hold_d = hold_q + 8'd1;
                    end else begin
                        hold_d = 8'd0;
                        if (frame_q < FRAME_LAST) begin
                            frame_d = frame_q + 3'd1;
                        end else begin
                            done_d  = 1'b1;
                            frame_d = 3'd0;
                            cool_d  = 8'd0;
                            state_d = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
                        end
                    end
                end
            end
            COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (cool_q >= COOL_LAST) begin
                        cool_d  = 8'd0;
                        state_d = IDLE;
                    end else begin
                        cool_d = cool_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                frame_d = 3'd0;
                hold_d  = 8'd0;
                cool_d  = 8'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
        hit_d  = (state_d == PLAY) && (frame_d >= HIT_LO) && (frame_d <= HIT_HI);
    end

    // Address path: 11-bit compares so a sprite near the right/bottom edge never wraps.
    logic [10:0] dx, dy, sx, sy;
    logic [9:0]  lx_full, ly_full;
    logic [5:0]  lx, ly, lx_eff;
    logic        inside_d;
    logic [11:0] addr_d;
    logic        in_sprite_q;
    logic [11:0] addr_q;

    always_comb begin
        dx       = {1'b0, bus.DrawX};
        dy       = {1'b0, bus.DrawY};
        sx       = {1'b0, bus.sprite_x};
        sy       = {1'b0, bus.sprite_y};
        inside_d = (dx >= sx) && (dx < sx + BOX_W) && (dy >= sy) && (dy < sy + BOX_H);
        lx_full  = bus.DrawX - bus.sprite_x;
        ly_full  = bus.DrawY - bus.sprite_y;
        lx       = lx_full[5:0];
        ly       = ly_full[5:0];
`ifdef KNIGHT_ATK_MIRROR_EN
        lx_eff   = bus.facing_left ? (6'(SPRITE_W - 1) - lx) : lx;
`else
        lx_eff   = lx;
`endif
        addr_d   = inside_d ? (12'(ly) * 12'(SPRITE_W) + 12'(lx_eff)) : 12'd0;
    end

`ifndef KNIGHT_ATK_MIRROR_EN
    logic unused_facing_left;
    assign unused_facing_left = bus.facing_left;
`endif

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            in_sprite_q <= 1'b0;
            addr_q      <= 12'd0;
        end else begin
            in_sprite_q <= inside_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.rom_address = addr_q;
    assign bus.in_sprite   = in_sprite_q;
    assign bus.frame_sel   = frame_q;
    assign bus.busy        = busy_q;
    assign bus.hit_active  = hit_q;
    assign bus.attack_done = done_q;
    assign bus.fsm_state   = state_q;
endmodule
